// File: rtl/fp_mul_share_ctrl_pkg.sv
// Shared types and constants for the multiplier-sharing controller.
package fp_mul_share_ctrl_pkg;

  // Fixed latency of the attached fp_multiply_pipeline.
  localparam int FP_MUL_LATENCY = 4;

  // Rounding-mode encoding expected by the pipeline.
  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } fp_rm_e;

  // Exception flags, in the bit order used on resp_flags and fflags.
  typedef struct packed {
    logic inv;
    logic ovf;
    logic unf;
    logic inx;
  } fp_flags_t;

  // Round-robin pointer advance with wrap-around at n.
  function automatic int next_ptr(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fp_mul_share_ctrl_if.sv
// Requester-side bus of the multiplier-sharing controller.
//
// Handshake: a request for requester i transfers in a cycle where
// req_valid[i] && req_ready[i]; req_ready may depend on req_valid, never the
// reverse. Responses are one-cycle strobes on resp_valid with no backpressure,
// so every requester must take a result in the cycle it appears.
interface fp_mul_share_ctrl_if #(
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [32*N_REQ-1:0] req_a;
  logic [32*N_REQ-1:0] req_b;
  logic [3*N_REQ-1:0]  req_rm;
  logic [N_REQ-1:0]    resp_valid;
  logic [31:0]         resp_result;
  logic [3:0]          resp_flags;
  logic [4*N_REQ-1:0]  fflags;
  logic [N_REQ-1:0]    fflags_clr;

  modport master (
    output req_valid, req_a, req_b, req_rm, fflags_clr,
    input  req_ready, resp_valid, resp_result, resp_flags, fflags
  );

  modport slave (
    input  req_valid, req_a, req_b, req_rm, fflags_clr,
    output req_ready, resp_valid, resp_result, resp_flags, fflags
  );
endinterface

// File: rtl/fp_mul_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping.
module fp_mul_share_ctrl_rr_arbiter #(
  parameter int N = 3,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         any
);
  int j;

  // Scan upward from ptr and take the first asserted request.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = W'(j);
      end
    end
  end
endmodule

// File: rtl/fp_mul_share_ctrl.sv
// Shares one fixed-latency FP multiply pipeline among N_REQ requesters and
// routes each result back to its issuer through a tag delay line.
module fp_mul_share_ctrl
  import fp_mul_share_ctrl_pkg::*;
#(
  parameter int N_REQ       = 3,
  parameter int MUL_LATENCY = FP_MUL_LATENCY,
  parameter int TAG_W       = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  fp_mul_share_ctrl_if.slave  bus,
  output logic                mul_valid,
  output logic [31:0]         mul_in1,
  output logic [31:0]         mul_in2,
  output logic [2:0]          mul_rm,
  input  logic [31:0]         mul_out,
  input  logic                mul_ovf,
  input  logic                mul_unf,
  input  logic                mul_inx,
  input  logic                mul_inv,
  input  logic                mul_valid_out,
  output logic                proto_err
);
  logic [N_REQ-1:0] grant;
  logic [TAG_W-1:0] win_idx;
  logic             win_any;
  logic [31:0]      win_a, win_b;
  logic [2:0]       win_rm;
  logic             issue;

  logic [TAG_W-1:0] rr_ptr;
  logic             rm_lock;
  logic [2:0]       cur_rm;

  // Tag line: entry 0 follows mul_valid, entry MUL_LATENCY lines up with mul_valid_out.
  logic [MUL_LATENCY:0]            tag_v;
  logic [MUL_LATENCY:0][TAG_W-1:0] tag_id;

  fp_flags_t        pipe_flags;
  logic [3:0]       flag_bits;
  logic             resp_fire;
  logic [N_REQ-1:0] resp_next;

  fp_mul_share_ctrl_rr_arbiter #(.N(N_REQ), .W(TAG_W)) u_arb (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  // Pick the winner's operand slices.
  always_comb begin
    win_a  = '0;
    win_b  = '0;
    win_rm = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        win_a  = bus.req_a[32*i +: 32];
        win_b  = bus.req_b[32*i +: 32];
        win_rm = bus.req_rm[3*i +: 3];
      end
    end
  end

  // A winner with a different rm right after an issue waits one bubble; no
  // other requester is picked in its place, which keeps everyone starvation-free.
  assign issue         = win_any && (!rm_lock || (win_rm == cur_rm));
  assign bus.req_ready = issue ? grant : '0;
  assign mul_rm        = cur_rm;

  assign pipe_flags = {mul_inv, mul_ovf, mul_unf, mul_inx};
  assign flag_bits  = pipe_flags;
  assign resp_fire  = mul_valid_out && tag_v[MUL_LATENCY];

  // Decode the tail tag into the next-cycle response strobe.
  always_comb begin
    resp_next = '0;
    for (int i = 0; i < N_REQ; i++) begin
      resp_next[i] = resp_fire && (tag_id[MUL_LATENCY] == TAG_W'(i));
    end
  end

  // Issue stage: register pipeline inputs, advance pointer, track rm lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_valid <= 1'b0;
      mul_in1   <= '0;
      mul_in2   <= '0;
      cur_rm    <= '0;
      rm_lock   <= 1'b0;
      rr_ptr    <= '0;
    end else begin
      mul_valid <= issue;
      if (issue) begin
        mul_in1 <= win_a;
        mul_in2 <= win_b;
        cur_rm  <= win_rm;
        rm_lock <= 1'b1;
        rr_ptr  <= TAG_W'(next_ptr(int'(win_idx), N_REQ));
      end else begin
        rm_lock <= 1'b0;
      end
    end
  end

  // Tag delay line, cleared on reset so in-flight results are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v  <= {tag_v[MUL_LATENCY-1:0], issue};
      tag_id <= {tag_id[MUL_LATENCY-1:0], win_idx};
    end
  end

  // Response register and sticky protocol-error detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.resp_valid  <= '0;
      bus.resp_result <= '0;
      bus.resp_flags  <= '0;
      proto_err       <= 1'b0;
    end else begin
      bus.resp_valid <= resp_next;
      if (resp_fire) begin
        bus.resp_result <= mul_out;
        bus.resp_flags  <= flag_bits;
      end
      if (mul_valid_out != tag_v[MUL_LATENCY]) begin
        proto_err <= 1'b1;
      end
    end
  end

  // Sticky per-requester flags; a coinciding clear still keeps the new flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.fflags <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        bus.fflags[4*i +: 4] <= (bus.fflags_clr[i] ? 4'b0 : bus.fflags[4*i +: 4])
                              | (resp_next[i] ? flag_bits : 4'b0);
      end
    end
  end
endmodule

// File: doc/fp_mul_share_ctrl.md
Name: fp_mul_share_ctrl

Overview:
- Shares one fp_multiply_pipeline instance (fixed latency, no stall input) among N requesters, e.g. scalar core, vector lane and DMA-side normaliser.
- Round-robin arbitration with a valid/ready handshake on each requester port.
- A tag delay line routes each result back to the requester that issued it.
- Keeps per-requester sticky exception flags (fflags) for CSR readback.

Parameters:
N_REQ, 3, number of requesters (2..8)
MUL_LATENCY, 4, cycles from mul_valid high to mul_valid_out high; must equal the attached pipeline's latency
TAG_W, $clog2(N_REQ), requester index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  N_REQ  operation request per requester
req_ready  out  N_REQ  accept per requester (combinational from state and req_valid)
req_a  in  32*N_REQ  operand 1, slice i for requester i
req_b  in  32*N_REQ  operand 2
req_rm  in  3*N_REQ  rounding mode (fp_pkg encoding)
resp_valid  out  N_REQ  one-hot, one-cycle result strobe
resp_result  out  32  result, shared by all requesters
resp_flags  out  4  {invalid, overflow, underflow, inexact} for the current response
fflags  out  4*N_REQ  sticky flags per requester
fflags_clr  in  N_REQ  clear sticky flags of requester i
mul_valid  out  1  to pipeline valid_data_in
mul_in1, mul_in2  out  32  to pipeline operands
mul_rm  out  3  to pipeline rounding_mode
mul_out  in  32  from pipeline
mul_ovf, mul_unf, mul_inx, mul_inv  in  1  from pipeline flags
mul_valid_out  in  1  from pipeline
proto_err  out  1  sticky: pipeline valid does not match the tag line

Behaviour:
- Interface: one clock, clk. Synchronous, active-high reset rst.
- Reset values: all outputs 0; rr pointer = 0; rm_lock = 0; cur_rm = 0; tag line cleared.
- Reset mid-operation drops all in-flight tags. The pipeline shares rst, so no stale result may reach any requester.
- Arbitration: winner = first i with req_valid[i], searching upward from rr_ptr with wrap-around.
- Issue condition: winner exists AND (!rm_lock OR req_rm[winner] == cur_rm).
- req_ready[winner] = issue condition; all other req_ready = 0.
- The rounding-mode check applies only to the winner. A winner whose rm differs forces a bubble; no other requester is selected instead. This is the starvation-freedom guarantee.
- On issue (cycle t):
  - mul_valid, mul_in1/in2 and mul_rm are registered from the winner and are valid in cycle t+1.
  - rr_ptr <= winner+1, wrapping at N_REQ.
  - cur_rm <= req_rm[winner].
  - rm_lock <= 1.
- No issue in cycle t: mul_valid <= 0. mul_in1/in2 and mul_rm hold their values. rm_lock <= 0.
- Reason for the rm rule: the pipeline samples rounding_mode in its first two stages. mul_rm must stay stable for the issue cycle and the following cycle, so back-to-back issues with different rm cost exactly one bubble.
- Tag line: shift register of depth MUL_LATENCY+1 holding {valid, tag}. Entry 0 is loaded with {mul_valid_next, winner}. The tail entry aligns with mul_valid_out.
- Result return:
  - When mul_valid_out = 1 and the tail entry is valid, in the next cycle resp_valid[tail.tag] = 1 and resp_result/resp_flags carry the registered pipeline outputs.
  - End-to-end latency: handshake at t gives resp_valid at t+MUL_LATENCY+2.
  - Throughput: one result per cycle.
- Mismatch: mul_valid_out differs from the tail entry's valid bit -> proto_err <= 1, held until rst. The response is suppressed.
- Sticky flags: fflags[i] <= (fflags_clr[i] ? 0 : fflags[i]) | (resp_valid_next[i] ? flags : 0). A same-cycle clear and update keeps the new flags.
- Requesters must accept every response; there is no response backpressure.

Decomposition:
- fp_pkg additions:
  - fp_flags_t: packed {inv, ovf, unf, inx}.
  - Rounding-mode enum, reused.
  - Constant FP_MUL_LATENCY = 4.
- Sub-module rr_arbiter: parameterised N, inputs req and ptr, outputs one-hot winner and winner index; combinational.
- The tag line and fflags stay in this module.

Test Plan:
- Single request: requester 1 issues a=0x40000000 (2.0), b=0x40400000 (3.0), rm=RNE at t=0. Required: resp_valid=3'b010 at t=6, resp_result=0x40C00000, flags 0, fflags[1]=0.
- All 3 requesters valid every cycle, same rm. Required: grants rotate 0,1,2,0,... with no bubbles, and each response is routed to the requester that issued it.
- Requester 0 rm=RNE and requester 1 rm=RTZ, both valid. Required: issue r0 at t, no issue at t+1, r1 issues at t+2; r2 never skipped.
- Overflow case 0x7F000000*0x7F000000, RNE, requester 2. Required: resp_result=0x7F800000, flags=4'b0101, and fflags[2] stays set until fflags_clr[2]. A clear that coincides with a new inexact response leaves 4'b0001.
- rst asserted for 1 cycle with 3 operations in flight. Required: no resp_valid afterwards, fflags=0, proto_err=0, and a new request completes normally.
- Mock pipeline injects a spurious mul_valid_out with the tag line empty. Required: proto_err=1 and no resp_valid.
